// File: rtl/switches_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : switches_pkg
//  Description : Shared constants, event record type and a lowest-set-bit
//                helper for the player switch front end.
//  Revision    : 1.0 - initial release
// ============================================================================
package switches_pkg;

    localparam int NUM_SWITCHES = 8;
    localparam int IDX_W        = 3;
    localparam int CNT_W        = 4;

    localparam logic PLAYER_P1 = 1'b0;
    localparam logic PLAYER_P2 = 1'b1;

    // One queued/in-flight switch event.
    typedef struct packed {
        logic             player;
        logic [IDX_W-1:0] index;
        logic             pressed;
    } evt_t;

    // Index of the lowest set bit; 0 when the vector is empty.
    function automatic logic [IDX_W-1:0] lowest_index(input logic [NUM_SWITCHES-1:0] v);
        lowest_index = '0;
        for (int i = NUM_SWITCHES - 1; i >= 0; i--) begin
            if (v[i]) begin
                lowest_index = IDX_W'(i);
            end
        end
    endfunction

endpackage
`default_nettype wire

// File: rtl/switch_event_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : switch_event_arbiter_if
//  Description : Valid/ready event port carrying {player, index, pressed}.
//                master = event producer (arbiter), slave = game logic.
//  Ports       : evt_valid, evt_ready, evt_player, evt_index, evt_pressed
//  Revision    : 1.0 - initial release
// ============================================================================
interface switch_event_arbiter_if;
    import switches_pkg::*;

    logic             evt_valid;
    logic             evt_ready;
    logic             evt_player;
    logic [IDX_W-1:0] evt_index;
    logic             evt_pressed;

    modport master (
        output evt_valid,
        output evt_player,
        output evt_index,
        output evt_pressed,
        input  evt_ready
    );

    modport slave (
        input  evt_valid,
        input  evt_player,
        input  evt_index,
        input  evt_pressed,
        output evt_ready
    );

endinterface
`default_nettype wire

// File: rtl/switch_debouncer.sv
`default_nettype none
// ============================================================================
//  Module      : switch_debouncer
//  Description : One 8-bit switch bank: 2-flop synchroniser, per-bit
//                tick-counted debounce, debounced level register and a
//                one-cycle edge strobe with the new level as direction.
//  Ports       : clk, reset (async, active-low), sample_tick,
//                i_switches (raw), o_db (debounced), o_edge (strobe,
//                coincides with the db update), o_dir (level being accepted)
//  Revision    : 1.0 - initial release
// ============================================================================
module switch_debouncer
    import switches_pkg::*;
#(
    parameter int STABLE = 3
) (
    input  wire logic                    clk,
    input  wire logic                    reset,
    input  wire logic                    sample_tick,
    input  wire logic [NUM_SWITCHES-1:0] i_switches,
    output logic      [NUM_SWITCHES-1:0] o_db,
    output logic      [NUM_SWITCHES-1:0] o_edge,
    output logic      [NUM_SWITCHES-1:0] o_dir
);

    logic [NUM_SWITCHES-1:0]            meta_q;
    logic [NUM_SWITCHES-1:0]            sync_q;
    logic [NUM_SWITCHES-1:0]            db_q;
    logic [NUM_SWITCHES-1:0]            db_d;
    logic [NUM_SWITCHES-1:0][CNT_W-1:0] cnt_q;
    logic [NUM_SWITCHES-1:0][CNT_W-1:0] cnt_d;
    logic [NUM_SWITCHES-1:0]            edge_w;

    // Counter only advances while the synchronised level disagrees with the
    // debounced one; any agreement restarts the stability window.
    always_comb begin
        db_d   = db_q;
        cnt_d  = cnt_q;
        edge_w = '0;
        for (int i = 0; i < NUM_SWITCHES; i++) begin
            if (sync_q[i] == db_q[i]) begin
                cnt_d[i] = '0;
            end else if (sample_tick) begin
                if (cnt_q[i] == CNT_W'(STABLE - 1)) begin
                    db_d[i]   = sync_q[i];
                    cnt_d[i]  = '0;
                    edge_w[i] = 1'b1;
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            meta_q <= '0;
            sync_q <= '0;
            db_q   <= '0;
            cnt_q  <= '0;
        end else begin
            meta_q <= i_switches;
            sync_q <= meta_q;
            db_q   <= db_d;
            cnt_q  <= cnt_d;
        end
    end

    assign o_db   = db_q;
    assign o_edge = edge_w;
    assign o_dir  = sync_q;

endmodule
`default_nettype wire

// File: rtl/switch_event_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : switch_event_arbiter
//  Description : Debounces two player switch banks, queues one pending event
//                per switch bit and arbitrates them round-robin between
//                players onto a single valid/ready event port.
//  Ports       : clk, reset (async, active-low), sample_tick,
//                switches_p1/p2 (raw), db_p1/p2 (debounced levels),
//                evt (event port, master side)
//  Revision    : 1.0 - initial release
// ============================================================================
module switch_event_arbiter
    import switches_pkg::*;
#(
    parameter int STABLE = 3
) (
    input  wire logic                    clk,
    input  wire logic                    reset,
    input  wire logic                    sample_tick,
    input  wire logic [NUM_SWITCHES-1:0] switches_p1,
    input  wire logic [NUM_SWITCHES-1:0] switches_p2,
    output logic      [NUM_SWITCHES-1:0] db_p1,
    output logic      [NUM_SWITCHES-1:0] db_p2,
    switch_event_arbiter_if.master       evt
);

    localparam int NUM_SLOTS = 2 * NUM_SWITCHES;

    // Slot numbering: {player, index}; player 1 in [7:0], player 2 in [15:8].
    logic [NUM_SLOTS-1:0] edge_w;
    logic [NUM_SLOTS-1:0] dir_new_w;
    logic [NUM_SLOTS-1:0] pending_q, pending_d;
    logic [NUM_SLOTS-1:0] dir_q, dir_d;
    logic                 last_player_q, last_player_d;
    logic                 valid_q, valid_d;
    evt_t                 evt_q, evt_d;

    logic                    w_any_p1;
    logic                    w_any_p2;
    logic                    w_loadable;
    logic                    w_pick;
    logic [NUM_SWITCHES-1:0] w_bank;
    logic [IDX_W-1:0]        w_idx;
    logic [IDX_W:0]          w_slot;
    logic [NUM_SLOTS-1:0]    w_clr;

    switch_debouncer #(.STABLE(STABLE)) u_deb_p1 (
        .clk         (clk),
        .reset       (reset),
        .sample_tick (sample_tick),
        .i_switches  (switches_p1),
        .o_db        (db_p1),
        .o_edge      (edge_w[NUM_SWITCHES-1:0]),
        .o_dir       (dir_new_w[NUM_SWITCHES-1:0])
    );

    switch_debouncer #(.STABLE(STABLE)) u_deb_p2 (
        .clk         (clk),
        .reset       (reset),
        .sample_tick (sample_tick),
        .i_switches  (switches_p2),
        .o_db        (db_p2),
        .o_edge      (edge_w[NUM_SLOTS-1:NUM_SWITCHES]),
        .o_dir       (dir_new_w[NUM_SLOTS-1:NUM_SWITCHES])
    );

    assign w_any_p1   = |pending_q[NUM_SWITCHES-1:0];
    assign w_any_p2   = |pending_q[NUM_SLOTS-1:NUM_SWITCHES];
    assign w_loadable = !valid_q || evt.evt_ready;
    // On a tie, alternate away from the player served last.
    assign w_pick     = (w_any_p1 && w_any_p2) ? ~last_player_q
                                               : (w_any_p2 ? PLAYER_P2 : PLAYER_P1);
    assign w_bank     = w_pick ? pending_q[NUM_SLOTS-1:NUM_SWITCHES]
                               : pending_q[NUM_SWITCHES-1:0];
    assign w_idx      = lowest_index(w_bank);
    assign w_slot     = {w_pick, w_idx};

    always_comb begin
        valid_d       = valid_q;
        evt_d         = evt_q;
        last_player_d = last_player_q;
        w_clr         = '0;
        if (w_loadable) begin
            if (w_any_p1 || w_any_p2) begin
                valid_d       = 1'b1;
                evt_d.player  = w_pick;
                evt_d.index   = w_idx;
                evt_d.pressed = dir_q[w_slot];
                w_clr[w_slot] = 1'b1;
                last_player_d = w_pick;
            end else begin
                valid_d = 1'b0;
            end
        end
        // A fresh edge re-arms its slot even if that slot is being loaded now,
        // and its direction always reflects the most recent debounced level.
        pending_d = (pending_q & ~w_clr) | edge_w;
        dir_d     = (dir_q & ~edge_w) | (dir_new_w & edge_w);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pending_q     <= '0;
            dir_q         <= '0;
            last_player_q <= PLAYER_P2;
            valid_q       <= 1'b0;
            evt_q         <= '0;
        end else begin
            pending_q     <= pending_d;
            dir_q         <= dir_d;
            last_player_q <= last_player_d;
            valid_q       <= valid_d;
            evt_q         <= evt_d;
        end
    end

    assign evt.evt_valid   = valid_q;
    assign evt.evt_player  = evt_q.player;
    assign evt.evt_index   = evt_q.index;
    assign evt.evt_pressed = evt_q.pressed;

endmodule
`default_nettype wire
